// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // Counter width able to hold every occupancy value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched {pc, instr} entries; storage is not reset,
// only the pointers and the occupancy count.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int ENTRY_W = WIDTH + INSTR_W,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [CNT_W-1:0]   count,
  output logic [ENTRY_W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Flush beats a same-cycle push or pop so a redirect always leaves the buffer empty.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one memory request
// in flight, and queues returned words for decode; a redirect kills everything in progress.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redir_valid,
  input  logic [WIDTH-1:0]   redir_pc,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  localparam int CNT_W   = cnt_w(DEPTH);
  localparam int ENTRY_W = WIDTH + INSTR_W;

  fetch_state_e       state_q, state_d;
  logic [WIDTH-1:0]   fpc_q, fpc_d;
  logic [WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   credit_limit;
  logic [ENTRY_W-1:0] head;
  logic               accept;
  logic               push;
  logic               pop;

  // A request issued from WAIT overlaps the pending push, so it needs one more free slot.
  assign credit_limit = (state_q == IDLE) ? CNT_W'(DEPTH) : CNT_W'(DEPTH - 1);

  assign imem_req  = !rst && !redir_valid && (count < credit_limit) &&
                     ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid));
  assign imem_addr = fpc_q;
  assign accept    = imem_req && imem_gnt;

  assign push      = !rst && !redir_valid && (state_q == WAIT) && imem_rvalid;
  assign out_valid = !rst && (count != '0);
  assign pop       = out_valid && out_ready;

  assign out_pc    = head[ENTRY_W-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    if (redir_valid) begin
      fpc_d = redir_pc & ~WIDTH'(PC_STEP - 1);
      unique case (state_q)
        WAIT:    state_d = imem_rvalid ? IDLE : DROP;
        DROP:    state_d = imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else if (accept) begin
      req_pc_d = fpc_q;
      fpc_d    = fpc_q + WIDTH'(PC_STEP);
      state_d  = WAIT;
    end else if (imem_rvalid && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redir_valid),
    .push_data({req_pc_q, imem_rdata}),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model of
// configurable latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t mq[$];

  fetch_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // Memory model: responses come back in order, lat cycles after the grant edge.
  always @(negedge clk) begin
    cyc++;
    imem_rvalid = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    if (imem_req && imem_gnt) begin
      mq.push_back('{imem_addr, cyc + lat});
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    @(negedge clk);
    rst         = r;
    redir_valid = rv;
    redir_pc    = rpc;
    out_ready   = rdy;
    #2;
  endtask

  task automatic collectPops(input int n, input logic [31:0] first_pc);
    logic [31:0] pc;
    int          got;
    pc  = first_pc;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid) begin
        checkOutput("pop_pc", out_pc, pc);
        checkOutput("pop_instr", out_instr, memWord(pc));
        pc = pc + 32'd4;
        got++;
      end
    end
    if (got < n) begin
      checkOutput("pop_timeout", 64'(got), 64'(n));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = '0;
    out_ready   = 1'b1;
    imem_gnt    = 1'b1;

    // Reset held two cycles, then streaming with single-cycle memory.
    lat = 1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_req0", 64'(imem_req), 64'd0);
    checkOutput("rst_valid0", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_req1", 64'(imem_req), 64'd0);
    checkOutput("rst_valid1", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("first_req", 64'(imem_req), 64'd1);
    checkOutput("first_addr", 64'(imem_addr), 64'h0);
    collectPops(8, 32'h0);

    // Backpressure fills the buffer and stops requests without losing words.
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp_req", 64'(imem_req), 64'd0);
    checkOutput("bp_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_head_pc", 64'(out_pc), 64'h20);
    checkOutput("bp_head_instr", 64'(out_instr), 64'(memWord(32'h20)));
    collectPops(6, 32'h20);

    // Redirect one cycle after the grant; the slow response must be discarded.
    lat = 3;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    mq.delete();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rw_req", 64'(imem_req), 64'd1);
    checkOutput("rw_addr", 64'(imem_addr), 64'h0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    checkOutput("rw_redir_noreq", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rw_drop_valid", 64'(out_valid), 64'd0);
    checkOutput("rw_drop_req", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rw_stale_req", 64'(imem_req), 64'd0);
    checkOutput("rw_stale_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rw_new_req", 64'(imem_req), 64'd1);
    checkOutput("rw_new_addr", 64'(imem_addr), 64'h100);
    collectPops(2, 32'h100);

    // Redirect coinciding with a response and a pop; target is realigned.
    lat = 1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    mq.delete();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rr_empty", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h203, 1'b1);
    checkOutput("rr_head_valid", 64'(out_valid), 64'd1);
    checkOutput("rr_head_pc", 64'(out_pc), 64'h0);
    checkOutput("rr_redir_req", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rr_flushed", 64'(out_valid), 64'd0);
    checkOutput("rr_req", 64'(imem_req), 64'd1);
    checkOutput("rr_addr", 64'(imem_addr), 64'h200);
    collectPops(3, 32'h200);

    // Back-to-back redirects from IDLE, last one wins, and the PC wraps.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    mq.delete();
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b1);
    checkOutput("bb_req0", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1);
    checkOutput("bb_req1", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_req", 64'(imem_req), 64'd1);
    checkOutput("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_addr1", 64'(imem_addr), 64'h0);
    collectPops(3, 32'hFFFF_FFFC);

    // Reset while a dropped fetch is outstanding; its late response must be ignored.
    lat = 3;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    mq.delete();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0);
    checkOutput("mr_buffered", 64'(out_valid), 64'd1);
    checkOutput("mr_buf_pc", 64'(out_pc), 64'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("mr_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mr_rst_req", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mr_after_valid", 64'(out_valid), 64'd0);
    checkOutput("mr_after_req", 64'(imem_req), 64'd1);
    checkOutput("mr_after_addr", 64'(imem_addr), 64'h0);
    collectPops(2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
